// File: rtl/trigger_logic_if.sv
// rtl/trigger_logic_if.sv - sample, config and capture-engine handshake bundle for trigger_logic
interface trigger_logic_if #(
    parameter int DW = 8
);
    logic          smpl_vld;
    logic [DW-1:0] ch1_smpl;
    logic [DW-1:0] ch2_smpl;
    logic [1:0]    trig_src;
    logic [1:0]    trig_type;
    logic [DW-1:0] trig_level;
    logic          ext_trig;
    logic          armed;
    logic          capture_done;
    logic          trigger;
    logic [15:0]   trig_cnt;

    modport master (
        output smpl_vld, ch1_smpl, ch2_smpl, trig_src, trig_type, trig_level,
        output ext_trig, armed, capture_done,
        input  trigger, trig_cnt
    );

    modport slave (
        input  smpl_vld, ch1_smpl, ch2_smpl, trig_src, trig_type, trig_level,
        input  ext_trig, armed, capture_done,
        output trigger, trig_cnt
    );
endinterface

// File: rtl/trigger_logic.sv
// rtl/trigger_logic.sv - level/edge trigger with hysteresis for the capture engine; optional re-arm holdoff under TRIG_HOLDOFF_EN
module trigger_logic #(
    parameter int DW      = 8,
    parameter int HYST    = 4,
    parameter int HOLDOFF = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    trigger_logic_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_PRE = 3'd1,
        S_WAIT_X   = 3'd2,
        S_FIRE     = 3'd3,
        S_HOLD     = 3'd4,
        S_HOLDOFF  = 3'd5
    } state_t;

    localparam logic [DW:0] HYST_X = (DW+1)'(HYST);
    localparam logic [DW:0] MAX_X  = {1'b0, {DW{1'b1}}};

    state_t      state_q, state_d;
    logic        trigger_q, trigger_d;
    logic [15:0] trig_cnt_q, trig_cnt_d;
    logic        sync1_q, sync2_q, prev_q;

`ifdef TRIG_HOLDOFF_EN
    localparam int HCW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    logic [HCW-1:0] hcnt_q, hcnt_d;
`endif

    logic [DW:0] level_x, lo_x, hi_x, smpl_x;
    logic        is_ext, is_rise, is_fall, is_force, is_off;
    logic        ext_rise, ext_fall, pre_ok, cross_ok;

    // Thresholds and crossing qualifiers; one extra bit keeps level+/-HYST from wrapping
    always_comb begin
        level_x  = {1'b0, bus.trig_level};
        lo_x     = (level_x >= HYST_X) ? (level_x - HYST_X) : '0;
        hi_x     = ((level_x + HYST_X) > MAX_X) ? MAX_X : (level_x + HYST_X);
        smpl_x   = (bus.trig_src == 2'b01) ? {1'b0, bus.ch2_smpl} : {1'b0, bus.ch1_smpl};
        is_ext   = (bus.trig_src == 2'b10);
        is_off   = (bus.trig_type == 2'b00);
        is_rise  = (bus.trig_type == 2'b01);
        is_fall  = (bus.trig_type == 2'b10);
        is_force = (bus.trig_type == 2'b11);
        ext_rise = sync2_q & ~prev_q;
        ext_fall = ~sync2_q & prev_q;
        pre_ok   = bus.smpl_vld && ((is_rise && (smpl_x <= lo_x)) ||
                                    (is_fall && (smpl_x >= hi_x)));
        if (is_ext) begin
            cross_ok = (is_rise && ext_rise) || (is_fall && ext_fall);
        end else begin
            cross_ok = bus.smpl_vld && ((is_rise && (smpl_x > level_x)) ||
                                        (is_fall && (smpl_x < level_x)));
        end
    end

    // Trigger FSM next state, held trigger and saturating fire counter
    always_comb begin
        state_d    = state_q;
        trigger_d  = trigger_q;
        trig_cnt_d = trig_cnt_q;
`ifdef TRIG_HOLDOFF_EN
        hcnt_d     = hcnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                trigger_d = 1'b0;
                if (bus.armed && !bus.capture_done && !is_off) begin
                    state_d = is_force ? S_FIRE : S_WAIT_PRE;
                end
            end
            S_WAIT_PRE: begin
                if (is_off || !bus.armed) begin
                    state_d = S_IDLE;
                end else if (is_force) begin
                    state_d = S_FIRE;
                end else if (is_ext || pre_ok) begin
                    state_d = S_WAIT_X;
                end
            end
            S_WAIT_X: begin
                // abort is checked first so an armed drop beats a same-cycle crossing
                if (is_off || !bus.armed) begin
                    state_d = S_IDLE;
                end else if (is_force || cross_ok) begin
                    state_d = S_FIRE;
                end
            end
            S_FIRE: begin
                if (is_off) begin
                    state_d = S_IDLE;
                end else begin
                    trigger_d  = 1'b1;
                    trig_cnt_d = (trig_cnt_q == 16'hFFFF) ? trig_cnt_q : (trig_cnt_q + 16'd1);
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.capture_done) begin
                    trigger_d = 1'b0;
`ifdef TRIG_HOLDOFF_EN
                    hcnt_d  = '0;
                    state_d = S_HOLDOFF;
`else
                    state_d = S_IDLE;
`endif
                end
            end
`ifdef TRIG_HOLDOFF_EN
            S_HOLDOFF: begin
                trigger_d = 1'b0;
                if (hcnt_q == HCW'(HOLDOFF - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
`endif
            default: begin
                trigger_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // Pin synchronizer, edge history and FSM registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
            state_q    <= S_IDLE;
            trigger_q  <= 1'b0;
            trig_cnt_q <= 16'd0;
`ifdef TRIG_HOLDOFF_EN
            hcnt_q     <= '0;
`endif
        end else begin
            sync1_q    <= bus.ext_trig;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            state_q    <= state_d;
            trigger_q  <= trigger_d;
            trig_cnt_q <= trig_cnt_d;
`ifdef TRIG_HOLDOFF_EN
            hcnt_q     <= hcnt_d;
`endif
        end
    end

    assign bus.trigger  = trigger_q;
    assign bus.trig_cnt = trig_cnt_q;

endmodule

// File: tb/tb_trigger_logic.sv
// tb/tb_trigger_logic.sv - vector-table and directed-sequence bench for trigger_logic
module tb_trigger_logic;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    trigger_logic_if #(.DW(8)) bus ();

    trigger_logic #(.DW(8), .HYST(4), .HOLDOFF(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  src;
        logic [1:0]  typ;
        logic [7:0]  lvl;
        logic        armed;
        logic        cd;
        logic        vld;
        logic [7:0]  c1;
        logic [7:0]  c2;
        logic        exp_trig;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(int src, int typ, int lvl, int arm, int cd, int vld,
                                int c1, int c2, int et, int ec);
        vec_t v;
        v.src = 2'(src);  v.typ = 2'(typ);  v.lvl = 8'(lvl);
        v.armed = 1'(arm); v.cd = 1'(cd);   v.vld = 1'(vld);
        v.c1 = 8'(c1);    v.c2 = 8'(c2);
        v.exp_trig = 1'(et); v.exp_cnt = 16'(ec);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int hi;
        int found;

        // rising, ch1, level 0x80
        vecs.push_back(mk(0,1,'h80,1,0,0,'h00,'h00,0,0));
        vecs.push_back(mk(0,1,'h80,1,0,1,'h90,'h00,0,0));
        vecs.push_back(mk(0,1,'h80,1,0,1,'h7C,'h00,0,0));
        vecs.push_back(mk(0,1,'h80,1,0,1,'h7E,'h00,0,0));
        vecs.push_back(mk(0,1,'h80,1,0,1,'h81,'h00,0,0));
        vecs.push_back(mk(0,1,'h80,1,0,0,'h81,'h00,1,1));
        vecs.push_back(mk(0,1,'h80,1,0,0,'h81,'h00,1,1));
        vecs.push_back(mk(0,1,'h80,1,1,0,'h81,'h00,0,1));
        vecs.push_back(mk(0,1,'h80,1,1,1,'h70,'h00,0,1));
        // falling, ch2, level 0x40, ch1 carries decoy values
        vecs.push_back(mk(1,2,'h40,1,0,0,'hFF,'h00,0,1));
        vecs.push_back(mk(1,2,'h40,1,0,1,'hFF,'h42,0,1));
        vecs.push_back(mk(1,2,'h40,1,0,1,'hFF,'h3F,0,1));
        vecs.push_back(mk(1,2,'h40,1,0,1,'hFF,'h43,0,1));
        vecs.push_back(mk(1,2,'h40,1,0,1,'h00,'h3E,0,1));
        vecs.push_back(mk(1,2,'h40,1,0,1,'h00,'h44,0,1));
        vecs.push_back(mk(1,2,'h40,1,0,1,'hFF,'h3F,0,1));
        vecs.push_back(mk(1,2,'h40,1,0,0,'hFF,'h3F,1,2));
        vecs.push_back(mk(1,2,'h40,1,1,0,'hFF,'h3F,0,2));
        vecs.push_back(mk(1,2,'h40,0,0,0,'h00,'h00,0,2));
        // rising, level 0x02: low threshold saturates at 0, smpl_vld gating
        vecs.push_back(mk(0,1,'h02,1,0,0,'h00,'h00,0,2));
        vecs.push_back(mk(0,1,'h02,1,0,1,'h01,'h00,0,2));
        vecs.push_back(mk(0,1,'h02,1,0,0,'h00,'h00,0,2));
        vecs.push_back(mk(0,1,'h02,1,0,1,'h00,'h00,0,2));
        vecs.push_back(mk(0,1,'h02,1,0,1,'h02,'h00,0,2));
        vecs.push_back(mk(0,1,'h02,1,0,0,'hFF,'h00,0,2));
        vecs.push_back(mk(0,1,'h02,1,0,1,'h03,'h00,0,2));
        vecs.push_back(mk(0,1,'h02,1,0,0,'h03,'h00,1,3));
        vecs.push_back(mk(0,1,'h02,1,1,0,'h03,'h00,0,3));
        // falling, reserved source (acts as ch1), level 0xFE: high threshold saturates at 0xFF
        vecs.push_back(mk(3,2,'hFE,1,0,0,'h00,'hFF,0,3));
        vecs.push_back(mk(3,2,'hFE,1,0,1,'hFE,'hFF,0,3));
        vecs.push_back(mk(3,2,'hFE,1,0,1,'hFF,'hFF,0,3));
        vecs.push_back(mk(3,2,'hFE,1,0,1,'hFE,'h00,0,3));
        vecs.push_back(mk(3,2,'hFE,1,0,1,'hFD,'h00,0,3));
        vecs.push_back(mk(3,2,'hFE,1,0,0,'hFD,'h00,1,4));
        vecs.push_back(mk(3,2,'hFE,1,1,0,'hFD,'h00,0,4));
        vecs.push_back(mk(3,2,'hFE,0,0,0,'h00,'h00,0,4));

        rst_n = 1'b0;
        bus.smpl_vld = 0; bus.ch1_smpl = 0; bus.ch2_smpl = 0;
        bus.trig_src = 0; bus.trig_type = 0; bus.trig_level = 0;
        bus.ext_trig = 0; bus.armed = 0; bus.capture_done = 0;
        tick(); tick();
        chk("reset_trigger", 32'(bus.trigger), 32'd0);
        chk("reset_cnt", 32'(bus.trig_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            bus.trig_src = vecs[i].src;   bus.trig_type = vecs[i].typ;
            bus.trig_level = vecs[i].lvl; bus.armed = vecs[i].armed;
            bus.capture_done = vecs[i].cd; bus.smpl_vld = vecs[i].vld;
            bus.ch1_smpl = vecs[i].c1;    bus.ch2_smpl = vecs[i].c2;
            tick();
            chk($sformatf("vec%0d_trig", i), 32'(bus.trigger), 32'(vecs[i].exp_trig));
            chk($sformatf("vec%0d_cnt", i), 32'(bus.trig_cnt), 32'(vecs[i].exp_cnt));
        end

        // hold for 50 cycles, release, no refire while capture_done stays high
        bus.trig_src = 0; bus.trig_type = 1; bus.trig_level = 8'h80;
        bus.armed = 1; bus.capture_done = 0; bus.smpl_vld = 0;
        tick();
        bus.smpl_vld = 1; bus.ch1_smpl = 8'h70; tick();
        bus.ch1_smpl = 8'h90; tick();
        bus.smpl_vld = 0; tick();
        chk("hold_fire", 32'(bus.trigger), 32'd1);
        hi = 0;
        repeat (50) begin tick(); if (bus.trigger) hi++; end
        chk("hold_50_cycles", 32'(hi), 32'd50);
        bus.capture_done = 1; tick();
        chk("hold_release", 32'(bus.trigger), 32'd0);
        hi = 0;
        bus.smpl_vld = 1;
        for (int i = 0; i < 6; i++) begin
            bus.ch1_smpl = i[0] ? 8'h90 : 8'h70;
            tick();
            if (bus.trigger) hi++;
        end
        chk("no_refire_while_done", 32'(hi), 32'd0);
        chk("hold_cnt", 32'(bus.trig_cnt), 32'd5);
        bus.capture_done = 0;
        bus.ch1_smpl = 8'h70; tick();
        tick();
        bus.ch1_smpl = 8'h90; tick();
        bus.smpl_vld = 0; tick();
        chk("refire_after_rearm", 32'(bus.trigger), 32'd1);
        chk("refire_cnt", 32'(bus.trig_cnt), 32'd6);
        bus.capture_done = 1; tick();
        bus.trig_type = 0; bus.capture_done = 0; tick();

        // external source, falling edge; glitch while disarmed is ignored
        bus.trig_src = 2; bus.trig_type = 2; bus.armed = 0; bus.ext_trig = 1;
        repeat (4) tick();
        #2 bus.ext_trig = 0;
        repeat (3) tick();
        bus.ext_trig = 1;
        hi = 0;
        repeat (8) begin tick(); if (bus.trigger) hi++; end
        chk("ext_glitch_disarmed", 32'(hi), 32'd0);
        bus.armed = 1;
        repeat (3) tick();
        #2 bus.ext_trig = 0;
        found = 0;
        for (int i = 0; i < 4 && found == 0; i++) begin
            tick();
            if (bus.trigger) found = 1;
        end
        chk("ext_fall_within_4", 32'(found), 32'd1);
        chk("ext_cnt", 32'(bus.trig_cnt), 32'd7);
        bus.capture_done = 1; tick();
        chk("ext_release", 32'(bus.trigger), 32'd0);
        bus.trig_type = 0; bus.capture_done = 0; tick();

        // force: trigger on the next-but-one cycle
        bus.trig_src = 0; bus.trig_type = 3; bus.armed = 1;
        tick();
        chk("force_first_cycle", 32'(bus.trigger), 32'd0);
        tick();
        chk("force_second_cycle", 32'(bus.trigger), 32'd1);
        chk("force_cnt", 32'(bus.trig_cnt), 32'd8);
        bus.capture_done = 1; tick();
        bus.trig_type = 0; bus.capture_done = 0; tick();

        // abort: armed falls on the same cycle as the crossing sample
        bus.trig_type = 1; bus.trig_level = 8'h80; bus.armed = 1;
        tick();
        bus.smpl_vld = 1; bus.ch1_smpl = 8'h70; tick();
        bus.armed = 0; bus.ch1_smpl = 8'h90; tick();
        chk("abort_same_cycle", 32'(bus.trigger), 32'd0);
        bus.smpl_vld = 0;
        hi = 0;
        repeat (2) begin tick(); if (bus.trigger) hi++; end
        bus.armed = 1; bus.smpl_vld = 1; bus.ch1_smpl = 8'h90;
        repeat (3) begin tick(); if (bus.trigger) hi++; end
        chk("abort_back_to_idle", 32'(hi), 32'd0);
        chk("abort_cnt", 32'(bus.trig_cnt), 32'd8);
        bus.smpl_vld = 0; bus.trig_type = 0; tick();

        // counter saturation, preloaded close to the top
        force dut.trig_cnt_q = 16'hFFFE;
        tick();
        release dut.trig_cnt_q;
        bus.trig_type = 3; tick(); tick();
        chk("sat_reach_ffff", 32'(bus.trig_cnt), 32'hFFFF);
        bus.capture_done = 1; tick();
        bus.capture_done = 0; tick(); tick();
        chk("sat_fire_trigger", 32'(bus.trigger), 32'd1);
        chk("sat_hold_ffff", 32'(bus.trig_cnt), 32'hFFFF);

        // asynchronous reset while in HOLD
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_hold_trigger", 32'(bus.trigger), 32'd0);
        chk("rst_in_hold_cnt", 32'(bus.trig_cnt), 32'd0);
        bus.trig_type = 0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("after_rst_trigger", 32'(bus.trigger), 32'd0);
        chk("after_rst_cnt", 32'(bus.trig_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trigger_logic.md
Name: trigger_logic

Overview:
- Generates the single-bit `trigger` consumed by the capture engine.
- Selects one of two analog channels, or an external trigger pin, and detects a qualified rising or falling crossing of a programmable level with hysteresis.
- Only detects while the capture engine reports `armed`; holds `trigger` high until the capture engine reports `capture_done`.
- Sits between the ADC sample path / config registers and the capture engine.

Parameters:
- DW, 8, sample and level width in bits.
- HYST, 4, hysteresis in LSBs; a crossing must first pass beyond level∓HYST.
- HOLDOFF, 64, cycles of re-arm holdoff (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- smpl_vld  in  1  one-cycle strobe; ch1_smpl/ch2_smpl are valid this cycle
- ch1_smpl  in  DW  channel 1 sample (unsigned)
- ch2_smpl  in  DW  channel 2 sample (unsigned)
- trig_src  in  2  00=ch1, 01=ch2, 10=external pin, 11=reserved (treated as 00)
- trig_type  in  2  00=disabled, 01=rising edge, 10=falling edge, 11=force
- trig_level  in  DW  comparison level (unsigned)
- ext_trig  in  1  asynchronous external trigger pin
- armed  in  1  capture engine has filled its pre-trigger region
- capture_done  in  1  capture engine has finished the record
- trigger  out  1  held trigger to the capture engine
- trig_cnt  out  16  saturating count of triggers fired since reset

Behaviour:
- Reset: trigger=0, trig_cnt=0, both synchronizer flops=0, FSM in IDLE, prev_ext=0.
- ext_trig path: 2-flop synchronizer, then a third flop holds the previous value; edge = sync vs prev. Latency from pin to a detectable edge is 2 cycles.
- Analog path:
  - Sample and level comparisons are evaluated only on smpl_vld cycles.
  - Compare thresholds: lo = level−HYST, saturating at 0; hi = level+HYST, saturating at 2^DW−1.
  - All comparisons are unsigned and use DW+1 bits internally, so there is no wrap.
- FSM states:
  - IDLE:
    - Go to WAIT_PRE when armed=1 and capture_done=0 and trig_type≠00.
    - trig_type=11 goes straight to FIRE instead.
  - WAIT_PRE (hysteresis pre-qualification):
    - Rising: wait for a valid sample ≤ lo.
    - Falling: wait for a valid sample ≥ hi.
    - On the qualifying sample, go to WAIT_X.
    - External source: skip directly to WAIT_X.
  - WAIT_X:
    - Rising: a valid sample > level goes to FIRE.
    - Falling: a valid sample < level goes to FIRE.
    - External source: a rising edge of the synced pin (trig_type=01) or a falling edge (10) goes to FIRE.
  - FIRE:
    - trigger is asserted registered, i.e. high from the cycle after entry.
    - trig_cnt increments once, saturating at 0xFFFF.
    - Go to HOLD.
  - HOLD:
    - trigger stays 1 until capture_done=1 is sampled.
    - Then trigger=0 and the FSM goes to IDLE.
- Abort paths:
  - If armed falls in WAIT_PRE or WAIT_X, return to IDLE; trigger stays 0.
  - If trig_type becomes 00 in any state other than HOLD, return to IDLE.
- HOLD is immune to config changes; only capture_done or reset exits it.
- Simultaneous qualifying sample and armed fall in WAIT_X: abort wins, no trigger.
- Re-arm: IDLE must see capture_done=0 again before leaving. No retrigger occurs while capture_done stays high.
- Total latency, analog: crossing sample on a smpl_vld cycle → trigger high 2 cycles later (WAIT_X→FIRE, FIRE→trigger registered).
- Reset mid-operation: everything returns immediately to reset values. trig_cnt clears.

Optional Feature:
- TRIG_HOLDOFF_EN defined:
  - After HOLD exits, the FSM enters HOLDOFF and counts HOLDOFF cycles.
  - It then goes to IDLE; armed is ignored during the count.
- Undefined:
  - No HOLDOFF state; HOLD exits directly to IDLE. The HOLDOFF parameter is unused.

Test Plan:
- Rising edge, ch1, level=0x80, HYST=4:
  - Stimulus: armed=1, samples 0x90,0x7C,0x7E,0x81 on smpl_vld.
  - Required: no trigger on 0x90 (no pre-qualification yet).
  - Required: pre-qualifies at 0x7C; trigger=1 two cycles after 0x81; trig_cnt=1.
- Hysteresis reject: falling, ch2, level=0x40.
  - Stimulus: samples 0x42,0x3F,0x43,0x3E.
  - Required: trigger stays 0 (never ≥0x44).
  - Then stimulus: 0x44, 0x3F → trigger fires.
- Hold/release:
  - Stimulus: after firing, keep capture_done=0 for 50 cycles, then pulse capture_done=1.
  - Required: trigger high the whole 50 cycles; drops the cycle after capture_done sampled.
  - Required: no refire until capture_done=0 and armed=1 again.
- External source, trig_type=10:
  - Stimulus: ext_trig falls asynchronously.
  - Required: trigger=1 within 4 cycles. A pin glitch while armed=0 is ignored.
- Force and abort:
  - Stimulus: trig_type=11 with armed=1 → trigger next-but-one cycle.
  - Stimulus: separately, rising mode pre-qualified, then armed=0 on the same cycle as a crossing sample.
  - Required: trigger stays 0, FSM returns to IDLE.
- Saturation/reset:
  - Stimulus: force trig_cnt to 0xFFFF via 65535 fire/release loops, then fire again.
  - Required: trig_cnt stays 0xFFFF.
  - Stimulus: assert rst_n=0 in HOLD.
  - Required: trigger=0 and trig_cnt=0 immediately.
